grid_trace_tracker: RTL and testbench

Parametrised successor to the fixed 4x4 IR box overlay. It maps an NUM_ROWS x NUM_COLS grid of IR sensors onto rectangular screen boxes, debounces each active-low sensor and latches "traced" cells until cleared. Each pixel query from the VGA scan gets a registered in-box flag and a colour. It sits between the IR sensor bank and the VGA pixel mux, and reports progress (count, all-done, new-hit pulses) to the game FSM.

---
 rtl/grid_trace_pkg.sv | 29 ++
 rtl/trace_debounce.sv | 33 +++
 rtl/grid_trace_tracker.sv | 146 ++++++++++++++
 tb/tb_grid_trace_tracker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/grid_trace_pkg.sv
// Shared constants and types for the IR grid trace tracker: cell-count and
// counter-width helpers, default colours and the pixel classification enum.
package grid_trace_pkg;

  localparam int COUNT_W = 7;

  localparam logic [7:0] DEF_LIVE_COLOR  = 8'd15;
  localparam logic [7:0] DEF_TRACE_COLOR = 8'd28;

  typedef enum logic [1:0] {
    PIX_UNLIT  = 2'd0,
    PIX_LIVE   = 2'd1,
    PIX_TRACED = 2'd2
  } pix_class_e;

  typedef struct packed {
    logic       in_box;
    logic [7:0] color;
  } pix_out_t;

  function automatic int cell_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int debounce_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/trace_debounce.sv
// Per-cell debouncer for one active-low IR sensor: counts consecutive low
// cycles, saturating at DEBOUNCE, and flags the cell as pressed once there.
module trace_debounce
  import grid_trace_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ir,
  output logic pressed
);

  localparam int CW = debounce_width(DEBOUNCE);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (ir) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign pressed = (count == LIMIT);

endmodule

// File: rtl/grid_trace_tracker.sv
// Maps a NUM_ROWS x NUM_COLS IR sensor grid onto screen boxes, latches traced
// cells and produces a registered in-box flag and colour per VGA pixel query.
module grid_trace_tracker
  import grid_trace_pkg::*;
#(
  parameter int         NUM_ROWS    = 4,
  parameter int         NUM_COLS    = 4,
  parameter int         BOX_W       = 100,
  parameter int         BOX_H       = 100,
  parameter int         ORIGIN_X    = 120,
  parameter int         ORIGIN_Y    = 40,
  parameter int         DEBOUNCE    = 4,
  parameter logic [7:0] LIVE_COLOR  = DEF_LIVE_COLOR,
  parameter logic [7:0] TRACE_COLOR = DEF_TRACE_COLOR,
  localparam int        N           = cell_count(NUM_ROWS, NUM_COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         row,
  input  logic [9:0]         col,
  input  logic [N-1:0]       ir_in,
  input  logic               sticky_en,
  input  logic               clear_traced,
  output logic               color_in_box,
  output logic [7:0]         box_color,
  output logic [N-1:0]       traced_mask,
  output logic [COUNT_W-1:0] traced_count,
  output logic               all_traced,
  output logic               hit_pulse,
  output logic [N-1:0]       hit_mask
);

  logic [NUM_ROWS-1:0] in_row;
  logic [NUM_COLS-1:0] in_col;
  logic [N-1:0]        in_cell;
  logic [N-1:0]        pressed;
  logic [N-1:0]        set_mask;
  logic [COUNT_W-1:0]  count_next;
  pix_class_e          pix_class;
  pix_out_t            pix_next;

  logic [31:0] row_w;
  logic [31:0] col_w;
  assign row_w = 32'(row);
  assign col_w = 32'(col);

  // Row and column windows are decoded once and combined per cell; bounds
  // are half-open so adjacent boxes never share a pixel.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    localparam int unsigned TOP = ORIGIN_Y + r * BOX_H;
    localparam int unsigned BOT = TOP + BOX_H;
    assign in_row[r] = (row_w >= TOP) && (row_w < BOT);
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int unsigned LEFT  = ORIGIN_X + c * BOX_W;
    localparam int unsigned RIGHT = LEFT + BOX_W;
    assign in_col[c] = (col_w >= LEFT) && (col_w < RIGHT);
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_cell_r
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_cell_c
      assign in_cell[r*NUM_COLS + c] = in_row[r] & in_col[c];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_debounce
    trace_debounce #(
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .ir      (ir_in[i]),
      .pressed (pressed[i])
    );
  end

  // Only cells pressed and not yet latched can set; sticky_en gates new sets.
  assign set_mask = sticky_en ? (pressed & ~traced_mask) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      traced_mask <= '0;
      hit_mask    <= '0;
      hit_pulse   <= 1'b0;
    end else if (clear_traced) begin
      traced_mask <= '0;
      hit_mask    <= '0;
      hit_pulse   <= 1'b0;
    end else begin
      traced_mask <= traced_mask | set_mask;
      hit_mask    <= set_mask;
      hit_pulse   <= |set_mask;
    end
  end

  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + COUNT_W'(traced_mask[i]);
    end
  end

  // Status lags the mask by one cycle by design.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      traced_count <= '0;
      all_traced   <= 1'b0;
    end else begin
      traced_count <= count_next;
      all_traced   <= &traced_mask;
    end
  end

  // Cells are disjoint, so at most one bit of in_cell is set per pixel.
  always_comb begin
    pix_class = PIX_UNLIT;
    if (|(in_cell & traced_mask)) begin
      pix_class = PIX_TRACED;
    end else if (|(in_cell & pressed)) begin
      pix_class = PIX_LIVE;
    end
  end

  always_comb begin
    pix_next = '0;
    case (pix_class)
      PIX_TRACED: pix_next = '{in_box: 1'b1, color: TRACE_COLOR};
      PIX_LIVE:   pix_next = '{in_box: 1'b1, color: LIVE_COLOR};
      default:    pix_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_in_box <= 1'b0;
      box_color    <= '0;
    end else begin
      color_in_box <= pix_next.in_box;
      box_color    <= pix_next.color;
    end
  end

endmodule

// File: tb/tb_grid_trace_tracker.sv
// Self-checking bench for grid_trace_tracker at default parameters: directed
// scenarios plus a random phase, all compared against a behavioural model.
module tb_grid_trace_tracker;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    row;
  logic [9:0]    col;
  logic [N-1:0]  ir_in;
  logic          sticky_en;
  logic          clear_traced;
  logic          color_in_box;
  logic [7:0]    box_color;
  logic [N-1:0]  traced_mask;
  logic [6:0]    traced_count;
  logic          all_traced;
  logic          hit_pulse;
  logic [N-1:0]  hit_mask;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  // Reference model: length of the current low run per sensor and latched set.
  int           streak [N];
  logic [N-1:0] m_traced;

  grid_trace_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .row          (row),
    .col          (col),
    .ir_in        (ir_in),
    .sticky_en    (sticky_en),
    .clear_traced (clear_traced),
    .color_in_box (color_in_box),
    .box_color    (box_color),
    .traced_mask  (traced_mask),
    .traced_count (traced_count),
    .all_traced   (all_traced),
    .hit_pulse    (hit_pulse),
    .hit_mask     (hit_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) streak[i] = 0;
    m_traced = '0;
  endtask

  // Grid is 4x4 boxes of 100x100 starting at (row 40, col 120).
  function automatic logic [8:0] model_pixel(input int r, input int c,
                                             input logic [N-1:0] pr, input logic [N-1:0] tr);
    int idx;
    if (r < 40 || r >= 440 || c < 120 || c >= 520) return 9'd0;
    idx = ((r - 40) / 100) * 4 + (c - 120) / 100;
    if (tr[idx]) return {1'b1, 8'd28};
    if (pr[idx]) return {1'b1, 8'd15};
    return 9'd0;
  endfunction

  // One clock edge with the current inputs; predicts every output, then checks.
  task automatic cycle();
    logic [N-1:0] pr, set_m, exp_traced, exp_hit;
    logic [8:0]   exp_pix;
    int           exp_cnt;
    logic         exp_all;
    for (int i = 0; i < N; i++) pr[i] = (streak[i] >= 4);
    exp_pix    = model_pixel(int'(row), int'(col), pr, m_traced);
    set_m      = sticky_en ? (pr & ~m_traced) : '0;
    exp_hit    = clear_traced ? '0 : set_m;
    exp_traced = clear_traced ? '0 : (m_traced | set_m);
    exp_cnt    = $countones(m_traced);
    exp_all    = (m_traced == {N{1'b1}});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) streak[i] = ir_in[i] ? 0 : streak[i] + 1;
    m_traced = exp_traced;
    if (hit_pulse === 1'b1) pulses++;
    check("traced_mask",  64'(traced_mask),  64'(exp_traced));
    check("hit_mask",     64'(hit_mask),     64'(exp_hit));
    check("hit_pulse",    64'(hit_pulse),    64'(|exp_hit));
    check("traced_count", 64'(traced_count), 64'(exp_cnt));
    check("all_traced",   64'(all_traced),   64'(exp_all));
    check("color_in_box", 64'(color_in_box), 64'(exp_pix[8]));
    check("box_color",    64'(box_color),    64'(exp_pix[7:0]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mask"},  64'(traced_mask),  64'd0);
    check({tag, "_count"}, 64'(traced_count), 64'd0);
    check({tag, "_all"},   64'(all_traced),   64'd0);
    check({tag, "_pulse"}, 64'(hit_pulse),    64'd0);
    check({tag, "_hit"},   64'(hit_mask),     64'd0);
    check({tag, "_inbox"}, 64'(color_in_box), 64'd0);
    check({tag, "_color"}, 64'(box_color),    64'd0);
  endtask

  task automatic pixel_at(input int r, input int c, input logic exp_in, input logic [7:0] exp_col);
    row = 9'(r);
    col = 10'(c);
    cycle();
    check($sformatf("pix_%0d_%0d_in", r, c),    64'(color_in_box), 64'(exp_in));
    check($sformatf("pix_%0d_%0d_color", r, c), 64'(box_color),    64'(exp_col));
  endtask

  initial begin
    // Reset state
    reset = 1'b1; row = '0; col = '0; ir_in = '1; sticky_en = 1'b1; clear_traced = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Cell 5 held low for DEBOUNCE edges latches on the following edge
    ir_in[5] = 1'b0;
    repeat (4) cycle();
    check("c5_no_early_hit", 64'(hit_pulse), 64'd0);
    cycle();
    check("c5_hit_pulse", 64'(hit_pulse), 64'd1);
    check("c5_hit_mask",  64'(hit_mask),  64'h0020);
    ir_in[5] = 1'b1;
    row = 9'd150; col = 10'd230;
    cycle();
    check("c5_count",    64'(traced_count), 64'd1);
    check("c5_pix_in",   64'(color_in_box), 64'd1);
    check("c5_pix_color", 64'(box_color),   64'd28);

    // A one-cycle release restarts the debounce
    pulses = 0;
    ir_in[0] = 1'b0;
    repeat (3) cycle();
    ir_in[0] = 1'b1;
    cycle();
    ir_in[0] = 1'b0;
    repeat (4) cycle();
    check("c0_no_latch_yet", 64'(pulses), 64'd0);
    cycle();
    check("c0_one_latch", 64'(pulses), 64'd1);
    check("c0_traced",    64'(traced_mask[0]), 64'd1);
    ir_in[0] = 1'b1;

    // Half-open box bounds, cell 0 latched
    pixel_at(39, 120, 1'b0, 8'd0);
    pixel_at(40, 119, 1'b0, 8'd0);
    pixel_at(440, 519, 1'b0, 8'd0);
    pixel_at(439, 520, 1'b0, 8'd0);
    pixel_at(40, 120, 1'b1, 8'd28);

    // Live display without latching
    pulses = 0;
    sticky_en = 1'b0;
    ir_in[15] = 1'b0;
    row = 9'd400; col = 10'd500;
    repeat (5) cycle();
    check("c15_live_color", 64'(box_color), 64'd15);
    check("c15_no_pulse",   64'(pulses),    64'd0);
    ir_in[15] = 1'b1;
    cycle();
    check("c15_release_lag", 64'(box_color), 64'd15);
    cycle();
    check("c15_unlit", 64'(color_in_box), 64'd0);

    // Latch the whole grid
    sticky_en = 1'b1;
    ir_in = '0;
    repeat (5) cycle();
    check("all_hit_mask", 64'(hit_mask), 64'hFFDE);
    cycle();
    check("all_count",  64'(traced_count), 64'd16);
    check("all_traced", 64'(all_traced),   64'd1);

    // Clear wins over a simultaneous set; a held grid re-latches after
    clear_traced = 1'b1;
    cycle();
    cycle();
    check("clr_mask",  64'(traced_mask), 64'd0);
    check("clr_pulse", 64'(hit_pulse),   64'd0);
    clear_traced = 1'b0;
    cycle();
    check("relatch_mask", 64'(hit_mask), 64'hFFFF);

    // Randomized phase
    ir_in = '1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) ir_in[i] = ~ir_in[i];
      sticky_en    = ($urandom_range(0, 9) != 0);
      clear_traced = ($urandom_range(0, 29) == 0);
      row          = 9'($urandom_range(0, 511));
      col          = 10'($urandom_range(0, 639));
      cycle();
    end

    // Asynchronous reset mid-operation
    sticky_en = 1'b1; clear_traced = 1'b0; ir_in = '1;
    row = 9'd60; col = 10'd340;
    repeat (2) cycle();
    ir_in[2] = 1'b0;
    repeat (5) cycle();
    ir_in[3] = 1'b0;
    repeat (2) cycle();
    #3 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    #2 reset = 1'b0;
    model_reset();
    repeat (4) cycle();
    check("post_rst_not_yet", 64'(traced_mask), 64'd0);
    cycle();
    check("post_rst_latch", 64'(traced_mask), 64'h000C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
